// File: rtl/sort_pkg.sv
// Constants shared by the sort engine blocks: response codes and default widths.
package sort_pkg;

  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;

  localparam int ADDR_WDTH = 4;
  localparam int DATA_WDTH = 32;

  function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/sort_mem_array.sv
// Word register file with reset-to-zero, one write port and two write-first read ports.
module sort_mem_array
  import sort_pkg::*;
#(
  parameter int ADDR_WDTH = sort_pkg::ADDR_WDTH,
  parameter int DATA_WDTH = sort_pkg::DATA_WDTH,
  parameter int MEM_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_we,
  input  logic [ADDR_WDTH-1:0] i_waddr,
  input  logic [DATA_WDTH-1:0] i_wdata,
  input  logic [ADDR_WDTH-1:0] i_raddr_a,
  output logic [DATA_WDTH-1:0] o_rdata_a,
  input  logic [ADDR_WDTH-1:0] i_raddr_b,
  output logic [DATA_WDTH-1:0] o_rdata_b
);

  logic [DATA_WDTH-1:0] r_mem [MEM_DEPTH];
  logic                 w_wr_ok;
  logic                 w_ra_ok;
  logic                 w_rb_ok;

  assign w_wr_ok = addr_in_range(32'(i_waddr), MEM_DEPTH);
  assign w_ra_ok = addr_in_range(32'(i_raddr_a), MEM_DEPTH);
  assign w_rb_ok = addr_in_range(32'(i_raddr_b), MEM_DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we && w_wr_ok) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Same-cycle write bypasses onto the read ports so readers see the new word.
  always_comb begin
    o_rdata_a = '0;
    o_rdata_b = '0;
    if (w_ra_ok) o_rdata_a = (i_we && i_waddr == i_raddr_a) ? i_wdata : r_mem[i_raddr_a];
    if (w_rb_ok) o_rdata_b = (i_we && i_waddr == i_raddr_b) ? i_wdata : r_mem[i_raddr_b];
  end

endmodule

// File: rtl/sort_mem_responder.sv
// Memory-side responder: AR/R and AW/W/B valid-ready channels plus a host preload/readback port.
module sort_mem_responder
  import sort_pkg::*;
#(
  parameter int ADDR_WDTH = sort_pkg::ADDR_WDTH,
  parameter int DATA_WDTH = sort_pkg::DATA_WDTH,
  parameter int RESP_WDTH = 1,
  parameter int MEM_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ar_valid,
  output logic                 ar_ready,
  input  logic [ADDR_WDTH-1:0] ar_address,
  output logic                 r_valid,
  input  logic                 r_ready,
  output logic [DATA_WDTH-1:0] r_data,
  output logic [RESP_WDTH-1:0] r_resp,
  input  logic                 aw_valid,
  output logic                 aw_ready,
  input  logic [ADDR_WDTH-1:0] aw_address,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic [DATA_WDTH-1:0] w_data,
  output logic                 b_valid,
  input  logic                 b_ready,
  output logic [RESP_WDTH-1:0] b_resp,
  input  logic                 host_we,
  input  logic [ADDR_WDTH-1:0] host_addr,
  input  logic [DATA_WDTH-1:0] host_wdata,
  output logic [DATA_WDTH-1:0] host_rdata
);

  localparam logic [RESP_WDTH-1:0] RESP_OK  = RESP_WDTH'(RESP_OKAY);
  localparam logic [RESP_WDTH-1:0] RESP_ERR = RESP_WDTH'(RESP_SLVERR);

  logic                 r_aw_full;
  logic [ADDR_WDTH-1:0] r_aw_addr;
  logic                 r_w_full;
  logic [DATA_WDTH-1:0] r_w_data;

  logic                 w_ar_hs;
  logic                 w_aw_hs;
  logic                 w_w_hs;
  logic                 w_commit;
  logic                 w_ar_ok;
  logic                 w_aw_ok;
  logic                 w_mem_we;
  logic [ADDR_WDTH-1:0] w_mem_waddr;
  logic [DATA_WDTH-1:0] w_mem_wdata;
  logic [DATA_WDTH-1:0] w_ar_rdata;
  logic [DATA_WDTH-1:0] w_host_rdata;

  assign ar_ready = ~rst & (~r_valid | r_ready);
  assign aw_ready = ~rst & ~r_aw_full;
  assign w_ready  = ~rst & ~r_w_full;

  assign w_ar_hs  = ar_valid & ar_ready;
  assign w_aw_hs  = aw_valid & aw_ready;
  assign w_w_hs   = w_valid & w_ready;
  assign w_commit = r_aw_full & r_w_full & (~b_valid | b_ready) & ~host_we;

  assign w_ar_ok = addr_in_range(32'(ar_address), MEM_DEPTH);
  assign w_aw_ok = addr_in_range(32'(r_aw_addr), MEM_DEPTH);

  // Host write wins the single write port; a pending commit simply waits.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = r_aw_addr;
    w_mem_wdata = r_w_data;
    if (host_we) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = host_addr;
      w_mem_wdata = host_wdata;
    end else if (w_commit) begin
      w_mem_we    = w_aw_ok;
    end
  end

  sort_mem_array #(
    .ADDR_WDTH (ADDR_WDTH),
    .DATA_WDTH (DATA_WDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_mem_we),
    .i_waddr   (w_mem_waddr),
    .i_wdata   (w_mem_wdata),
    .i_raddr_a (ar_address),
    .o_rdata_a (w_ar_rdata),
    .i_raddr_b (host_addr),
    .o_rdata_b (w_host_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_resp     <= '0;
      b_valid    <= 1'b0;
      b_resp     <= '0;
      host_rdata <= '0;
      r_aw_full  <= 1'b0;
      r_aw_addr  <= '0;
      r_w_full   <= 1'b0;
      r_w_data   <= '0;
    end else begin
      if (w_ar_hs) begin
        r_valid <= 1'b1;
        r_data  <= w_ar_rdata;
        r_resp  <= w_ar_ok ? RESP_OK : RESP_ERR;
      end else if (r_ready) begin
        r_valid <= 1'b0;
      end

      // aw_ready/w_ready are low while full, so a handshake never coincides with a commit.
      if (w_commit) begin
        r_aw_full <= 1'b0;
      end else if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_aw_addr <= aw_address;
      end

      if (w_commit) begin
        r_w_full <= 1'b0;
      end else if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_w_data <= w_data;
      end

      if (w_commit) begin
        b_valid <= 1'b1;
        b_resp  <= w_aw_ok ? RESP_OK : RESP_ERR;
      end else if (b_ready) begin
        b_valid <= 1'b0;
      end

      host_rdata <= w_host_rdata;
    end
  end

endmodule

// File: tb/tb_sort_mem_responder.sv
// Directed bench for sort_mem_responder with MEM_DEPTH=10 so out-of-range addresses are reachable.
module tb_sort_mem_responder;

  localparam int AW = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          ar_valid, ar_ready;
  logic [AW-1:0] ar_address;
  logic          r_valid, r_ready;
  logic [DW-1:0] r_data;
  logic [0:0]    r_resp;
  logic          aw_valid, aw_ready;
  logic [AW-1:0] aw_address;
  logic          w_valid, w_ready;
  logic [DW-1:0] w_data;
  logic          b_valid, b_ready;
  logic [0:0]    b_resp;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic [DW-1:0] host_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  sort_mem_responder #(
    .ADDR_WDTH (AW),
    .DATA_WDTH (DW),
    .RESP_WDTH (1),
    .MEM_DEPTH (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ar_valid   (ar_valid),
    .ar_ready   (ar_ready),
    .ar_address (ar_address),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .r_data     (r_data),
    .r_resp     (r_resp),
    .aw_valid   (aw_valid),
    .aw_ready   (aw_ready),
    .aw_address (aw_address),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_data     (w_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_resp     (b_resp),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] preload [4];

  initial begin
    preload[0] = 32'd7;
    preload[1] = 32'hFFFF_FFFE;
    preload[2] = 32'd5;
    preload[3] = 32'd0;

    rst = 1'b1;
    ar_valid = 0; ar_address = '0; r_ready = 0;
    aw_valid = 0; aw_address = '0; w_valid = 0; w_data = '0; b_ready = 0;
    host_we = 0; host_addr = '0; host_wdata = '0;
    #3;
    check("rst_r_valid",    32'(r_valid),  32'd0);
    check("rst_b_valid",    32'(b_valid),  32'd0);
    check("rst_ar_ready",   32'(ar_ready), 32'd0);
    check("rst_aw_ready",   32'(aw_ready), 32'd0);
    check("rst_w_ready",    32'(w_ready),  32'd0);
    check("rst_r_data",     r_data,        32'd0);
    check("rst_host_rdata", host_rdata,    32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_ar_ready", 32'(ar_ready), 32'd1);

    // Host preload mem[0..3]
    for (int i = 0; i < 4; i++) begin
      host_we = 1; host_addr = AW'(i); host_wdata = preload[i];
      tick();
    end
    host_we = 0;

    // Back-to-back reads with r_ready held high
    ar_valid = 1; r_ready = 1;
    for (int i = 0; i < 4; i++) begin
      ar_address = AW'(i);
      tick();
      check($sformatf("rd%0d_valid", i), 32'(r_valid), 32'd1);
      check($sformatf("rd%0d_data", i),  r_data,        preload[i]);
      check($sformatf("rd%0d_resp", i),  32'(r_resp),  32'd0);
    end
    ar_valid = 0;
    tick();
    check("rd_drain_valid", 32'(r_valid), 32'd0);

    // Read backpressure
    r_ready = 0; ar_valid = 1; ar_address = 4'd2;
    tick();
    ar_valid = 0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp%0d_valid", i),    32'(r_valid),  32'd1);
      check($sformatf("bp%0d_data", i),     r_data,        32'd5);
      check($sformatf("bp%0d_ar_ready", i), 32'(ar_ready), 32'd0);
      tick();
    end
    r_ready = 1;
    #1;
    check("bp_release_ar_ready", 32'(ar_ready), 32'd1);
    tick();
    check("bp_done_valid", 32'(r_valid), 32'd0);

    // Split write: AW first, W three cycles later
    b_ready = 1;
    aw_valid = 1; aw_address = 4'd1;
    #1;
    check("sw_aw_ready0", 32'(aw_ready), 32'd1);
    tick();
    aw_valid = 0;
    for (int i = 1; i <= 3; i++) begin
      check($sformatf("sw_aw_ready%0d", i), 32'(aw_ready), 32'd0);
      if (i < 3) tick();
    end
    w_valid = 1; w_data = 32'h11;
    #1;
    check("sw_w_ready", 32'(w_ready), 32'd1);
    tick();
    w_valid = 0;
    check("sw_b_wait", 32'(b_valid), 32'd0);
    host_addr = 4'd1;
    tick();
    check("sw_b_valid", 32'(b_valid), 32'd1);
    check("sw_b_resp",  32'(b_resp),  32'd0);
    check("sw_host_rdata", host_rdata, 32'h11);
    check("sw_aw_ready_free", 32'(aw_ready), 32'd1);
    tick();
    check("sw_b_clear", 32'(b_valid), 32'd0);

    // Commit and AR to the same address in one cycle: write-first
    aw_valid = 1; aw_address = 4'd3; w_valid = 1; w_data = 32'hAA;
    tick();
    aw_valid = 0; w_valid = 0;
    ar_valid = 1; ar_address = 4'd3;
    tick();
    ar_valid = 0;
    check("col_ar_data",  r_data,         32'hAA);
    check("col_b_valid",  32'(b_valid),   32'd1);
    tick();

    // Host write in the commit cycle stalls the commit by one cycle
    aw_valid = 1; aw_address = 4'd3; w_valid = 1; w_data = 32'hBB;
    tick();
    aw_valid = 0; w_valid = 0;
    host_we = 1; host_addr = 4'd3; host_wdata = 32'h55;
    tick();
    check("hcol_stall_b", 32'(b_valid), 32'd0);
    check("hcol_host_first", host_rdata, 32'h55);
    host_we = 0;
    tick();
    check("hcol_commit_b", 32'(b_valid), 32'd1);
    check("hcol_final",    host_rdata,   32'hBB);

    // Host write and AR same address same cycle: write-first
    host_we = 1; host_addr = 4'd2; host_wdata = 32'h22;
    ar_valid = 1; ar_address = 4'd2;
    tick();
    host_we = 0; ar_valid = 0;
    check("hrd_data", r_data, 32'h22);
    tick();

    // Out of range (MEM_DEPTH = 10)
    ar_valid = 1; ar_address = 4'd12;
    tick();
    ar_valid = 0;
    check("oor_r_data", r_data,       32'd0);
    check("oor_r_resp", 32'(r_resp),  32'd1);
    aw_valid = 1; aw_address = 4'd15; w_valid = 1; w_data = 32'h99;
    tick();
    aw_valid = 0; w_valid = 0;
    host_addr = 4'd5;
    tick();
    check("oor_b_valid", 32'(b_valid), 32'd1);
    check("oor_b_resp",  32'(b_resp),  32'd1);
    host_addr = 4'd7;
    tick();
    check("oor_mem5", host_rdata, 32'd0);
    tick();
    check("oor_mem7", host_rdata, 32'd0);
    host_addr = 4'd0;
    tick();
    check("oor_mem0_kept", host_rdata, 32'd7);

    // Reset mid-transaction
    r_ready = 0; b_ready = 0;
    ar_valid = 1; ar_address = 4'd0; aw_valid = 1; aw_address = 4'd0;
    tick();
    ar_valid = 0; aw_valid = 0;
    check("mid_r_valid_pre", 32'(r_valid),  32'd1);
    check("mid_aw_full_pre", 32'(aw_ready), 32'd0);
    r_ready = 1;
    rst = 1;
    #1;
    check("mid_r_valid",  32'(r_valid),  32'd0);
    check("mid_b_valid",  32'(b_valid),  32'd0);
    check("mid_ar_ready", 32'(ar_ready), 32'd0);
    check("mid_aw_ready", 32'(aw_ready), 32'd0);
    check("mid_w_ready",  32'(w_ready),  32'd0);
    tick();
    rst = 0;
    #1;
    check("mid_aw_released", 32'(aw_ready), 32'd1);
    ar_valid = 1; ar_address = 4'd0; b_ready = 1;
    w_valid = 1; w_data = 32'h33;
    tick();
    ar_valid = 0; w_valid = 0;
    check("mid_rd0_valid", 32'(r_valid), 32'd1);
    check("mid_rd0_data",  r_data,        32'd0);
    tick();
    tick();
    check("mid_no_b", 32'(b_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sort_mem_responder.md
Name: sort_mem_responder

Overview:
Memory-side responder for the sort engine's memory interface.
- Serves read-address/read-data requests and write-address/write-data/write-response transactions against an internal word array, using valid/ready handshakes.
- Has a host port so test software can preload the unsorted array and read back the result.
- Sits between the sort controller/datapath and the write submodule on one side, and the host on the other.

Parameters:
- ADDR_WDTH, 4: address width; array has 2**ADDR_WDTH word slots.
- DATA_WDTH, 32: word width.
- RESP_WDTH, 1: response code width (0 = OKAY, 1 = SLVERR).
- MEM_DEPTH, 16: implemented words, must be <= 2**ADDR_WDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- ar_valid  in  1  read request valid.
- ar_ready  out  1  read request accepted.
- ar_address  in  ADDR_WDTH  read word address.
- r_valid  out  1  read data valid.
- r_ready  in  1  requester takes read data.
- r_data  out  DATA_WDTH  read data.
- r_resp  out  RESP_WDTH  read response code.
- aw_valid / aw_ready  in/out  1  write address handshake.
- aw_address  in  ADDR_WDTH  write word address.
- w_valid / w_ready  in/out  1  write data handshake.
- w_data  in  DATA_WDTH  write data.
- b_valid  out  1  write response valid.
- b_ready  in  1  requester takes write response.
- b_resp  out  RESP_WDTH  write response code.
- host_we  in  1  host write strobe.
- host_addr  in  ADDR_WDTH  host word address.
- host_wdata  in  DATA_WDTH  host write data.
- host_rdata  out  DATA_WDTH  registered mem[host_addr], one cycle latency.

Behaviour:
- Reset (async, active-high): all valids 0; all readys 0 while rst=1; r_data, r_resp, b_resp, host_rdata = 0; AW/W holding registers empty; every memory word = 0.
- Address check: address >= MEM_DEPTH is out of range.
  - Out-of-range read returns r_data = 0, r_resp = 1.
  - Out-of-range write is not performed; b_resp = 1.
  - In-range accesses return resp = 0.
- Read channel:
  - ar_ready = ~r_valid | r_ready, which gives a single-outstanding, back-to-back capable pipeline.
  - An AR handshake at edge T loads r_data/r_resp and sets r_valid after T (1-cycle latency).
  - r_valid stays high with r_data stable until r_valid & r_ready.
  - If there is no new AR handshake in that same cycle, r_valid clears.
- Write channel:
  - AW and W are independent, each with a 1-entry holding register: aw_ready = ~aw_full, w_ready = ~w_full.
  - Commit condition: aw_full & w_full & (~b_valid | b_ready) & ~host_we.
  - On commit: the memory is written if in range, b_valid is set with b_resp, and both holding registers clear at the same edge.
  - AW and W handshakes in the same cycle at edge T give commit at T+1 and b_valid after T+1.
  - b_valid stays high until b_ready.
- Ordering / collisions:
  - A write commit and an AR handshake to the same address in the same cycle is write-first: r_data returns the new word.
  - host_we has priority over an AXI commit; the commit stalls one cycle and nothing is dropped.
  - A host write and an AR handshake to the same address in the same cycle is also write-first.
- Host read: host_rdata <= mem[host_addr] every cycle, after any same-edge write, so it is write-first as well.
- Channels are fully independent; a stalled b_ready never blocks reads.
- Reset asserted mid-transaction discards held AW/W and pending R/B responses and clears the memory.

Decomposition:
- Shared package sort_pkg holds:
  - RESP_OKAY = 1'b0 and RESP_SLVERR = 1'b1 constants;
  - the default ADDR_WDTH/DATA_WDTH constants shared with the datapath.
- One sub-module, sort_mem_array, is natural:
  - write-first register file with reset-to-zero;
  - one write port (muxed host/AXI) and two read ports (AXI, host).
- Handshake logic stays in the top module.

Test Plan:
- Reset then host preload: host writes mem[0..3] = 7, -2, 5, 0; read via AR at 0..3 with r_ready=1 -> r_data = 7, 0xFFFFFFFE, 5, 0 on consecutive cycles, one cycle after each AR, r_resp = 0.
- Backpressure: AR addr 2 with r_ready=0 for 3 cycles -> r_valid high, r_data = 5 held, ar_ready=0; r_ready=1 -> transfer completes, ar_ready=1.
- Split write: aw_valid addr 1 at cycle 0, w_valid 0x11 at cycle 3 -> aw_ready low cycles 1-3, b_valid after cycle 4 with b_resp = 0; host_rdata at addr 1 = 0x11.
- Collision: commit write addr 3 = 0xAA in the same cycle as AR addr 3 -> r_data = 0xAA. host_we to addr 3 in the commit cycle -> commit delayed one cycle, final mem[3] = AXI data.
- Out of range with MEM_DEPTH=10: AR addr 12 -> r_data = 0, r_resp = 1. Write addr 15 -> b_resp = 1, no memory change.
- Reset mid-operation: rst pulse while r_valid=1 and aw_full=1 -> r_valid=0, b_valid=0, readys low during rst; after release, reads of addr 0 return 0.
